// File: rtl/pipe_add_sub_pkg.sv
// Shared constants, flag bundle and carry-slice width helper for pipe_add_sub.
package pipe_add_sub_pkg;

  localparam int unsigned PIPE_ADD_SUB_WIDTH_DEFAULT  = 32;
  localparam int unsigned PIPE_ADD_SUB_STAGES_DEFAULT = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } pipe_add_sub_flags_t;

  // Returns 0 for an illegal split so the top can reject the configuration at elaboration.
  function automatic int unsigned pipe_add_sub_chunk(input int unsigned width,
                                                     input int unsigned stages);
    if (stages == 0 || (width % stages) != 0) begin
      return 0;
    end
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_slice.sv
// Combinational W-bit adder: one link of the registered carry chain.
module add_slice
  import pipe_add_sub_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o
);

  logic [W:0] total;

  assign total         = {1'b0, a_i} + {1'b0, b_i} + (W+1)'(cin_i);
  assign {cout_o, s_o} = total;

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined add/sub: one CHUNK-bit carry slice per stage, valid/ready flow control.
// Define PIPE_ADD_SUB_FLAGS_EN to compute ovf/zero; otherwise both are tied to 0.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = PIPE_ADD_SUB_WIDTH_DEFAULT,
  parameter int unsigned STAGES = PIPE_ADD_SUB_STAGES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = pipe_add_sub_chunk(WIDTH, STAGES);

  if (CHUNK == 0) begin : g_bad_cfg
    $error("pipe_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  logic                advance;
  logic                last_valid;
  logic [WIDTH-1:0]    last_sum;
  pipe_add_sub_flags_t flags;

  // The whole pipe moves as one unit; it only stops when the final result is blocked.
  assign advance  = !last_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SRC_W = WIDTH - k * CHUNK;
    localparam int unsigned REM_W = SRC_W - CHUNK;
    localparam int unsigned RES_W = (k + 1) * CHUNK;

    // Operand bits still to be added (slice k at the bottom) and result bits so far.
    logic [SRC_W-1:0] a_src;
    logic [SRC_W-1:0] b_src;
    logic             c_src;
    logic             v_src;
    logic [CHUNK-1:0] s_slice;
    logic             c_slice;
    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] res_q;
    logic             carry_q;
    logic             valid_q;

    if (k == 0) begin : g_src
      assign a_src = a;
      assign b_src = sub ? ~b : b;
      assign c_src = sub;
      assign v_src = in_valid;
      assign res_d = s_slice;
    end else begin : g_src
      assign a_src = g_stage[k-1].g_skew.a_q;
      assign b_src = g_stage[k-1].g_skew.b_q;
      assign c_src = g_stage[k-1].carry_q;
      assign v_src = g_stage[k-1].valid_q;
      assign res_d = {s_slice, g_stage[k-1].res_q};
    end

    add_slice #(
      .W(CHUNK)
    ) u_slice (
      .a_i   (a_src[CHUNK-1:0]),
      .b_i   (b_src[CHUNK-1:0]),
      .cin_i (c_src),
      .s_o   (s_slice),
      .cout_o(c_slice)
    );

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (advance) begin
        valid_q <= v_src;
        carry_q <= c_slice;
        res_q   <= res_d;
      end
    end

    // Upper operand slices ride along until their stage is reached.
    if (k < STAGES - 1) begin : g_skew
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_src[SRC_W-1:CHUNK];
          b_q <= b_src[SRC_W-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      assign last_valid = valid_q;
      assign last_sum   = res_q;
`ifdef PIPE_ADD_SUB_FLAGS_EN
      logic ovf_d;
      logic zero_d;
      logic ovf_q;
      logic zero_q;

      // Overflow: like-signed operands producing a result of the other sign.
      assign ovf_d  = (a_src[SRC_W-1] == b_src[SRC_W-1]) && (res_d[RES_W-1] != a_src[SRC_W-1]);
      assign zero_d = ~|res_d;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign flags.cout = carry_q;
      assign flags.ovf  = ovf_q;
      assign flags.zero = zero_q;
`else
      assign flags.cout = carry_q;
      assign flags.ovf  = 1'b0;
      assign flags.zero = 1'b0;
`endif
    end
  end

  assign out_valid = last_valid;
  assign sum       = last_sum;
  assign cout      = flags.cout;
  assign ovf       = flags.ovf;
  assign zero      = flags.zero;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Directed and randomised checks of pipe_add_sub: a 32-bit/4-stage and an 8-bit/1-stage instance.
`timescale 1ns/1ps
module tb_pipe_add_sub;

`ifdef PIPE_ADD_SUB_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;

  logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;

  int checks   = 0;
  int failures = 0;

  res_t exp_q[$];

  always #5 clock = ~clock;

  pipe_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic res_t mask(input res_t r);
    res_t m;
    m = r;
    if (!FLAGS_EN) begin
      m.ovf  = 1'b0;
      m.zero = 1'b0;
    end
    return m;
  endfunction

  // Full-width reference: one 33-bit addition.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t        r;
    logic [31:0] eb;
    logic [32:0] t;
    eb     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, eb} + 33'(s);
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == eb[31]) && (t[31] != x[31]);
    r.zero = (t[31:0] == 32'd0);
    return r;
  endfunction

  task automatic drain(input string name);
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Output monitor: ordering, values, stall stability and the in_ready rule.
  logic        prev_stall;
  logic [31:0] prev_sum;
  logic [2:0]  prev_flags;
  res_t        mon_r;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_sum", sum, prev_sum);
        chk("stall_flags", 32'({cout, ovf, zero}), 32'(prev_flags));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: actual sum=%h with out_valid=1, required no output", sum);
        end else if (out_ready) begin
          mon_r = exp_q.pop_front();
          chk("out_sum", sum, mon_r.sum);
          chk("out_cout", 32'(cout), 32'(mon_r.cout));
          chk("out_ovf", 32'(ovf), 32'(mon_r.ovf));
          chk("out_zero", 32'(zero), 32'(mon_r.zero));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_sum   <= sum;
      prev_flags <= {cout, ovf, zero};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [9];
  vec_t        tbl8[3];
  res_t        e;
  logic [31:0] ra, rb;
  logic        rs, acc;

  initial begin
    tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'h12345678, 32'h0FEDCBA8, 1'b0, 32'h22222220, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h00010000, 32'h00000001, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};

    tbl8[0] = '{32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0};
    tbl8[1] = '{32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0};
    tbl8[2] = '{32'h3C, 32'h3C, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;

    // Reset state, with out_ready low so in_ready must still be 1.
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst8_out_valid", 32'(out_valid8), 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;

    // Latency: first op accepted on the first edge after deassertion, result STAGES cycles later.
    a = tbl[0].a; b = tbl[0].b; sub = tbl[0].sub; in_valid = 1'b1;
    tick();
    e = mask('{tbl[0].sum, tbl[0].cout, tbl[0].ovf, tbl[0].zero});
    exp_q.push_back(e);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("latency_valid_c%0d", c), 32'(out_valid), 32'(c == 4));
    end
    drain("latency");

    // Directed table streamed back to back.
    for (int i = 0; i < 9; i++) begin
      a = tbl[i].a; b = tbl[i].b; sub = tbl[i].sub; in_valid = 1'b1;
      tick();
      e = mask('{tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero});
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
    drain("table");

    // Single-stage 8-bit instance: result one cycle after accept.
    for (int i = 0; i < 3; i++) begin
      a8 = tbl8[i].a[7:0]; b8 = tbl8[i].b[7:0]; sub8 = tbl8[i].sub; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      @(negedge clock);
      chk($sformatf("w8_valid_%0d", i), 32'(out_valid8), 32'd1);
      chk($sformatf("w8_sum_%0d", i), 32'(sum8), tbl8[i].sum);
      chk($sformatf("w8_cout_%0d", i), 32'(cout8), 32'(tbl8[i].cout));
      chk($sformatf("w8_ovf_%0d", i), 32'(ovf8), 32'(FLAGS_EN && tbl8[i].ovf));
      chk($sformatf("w8_zero_%0d", i), 32'(zero8), 32'(FLAGS_EN && tbl8[i].zero));
      tick();
      chk($sformatf("w8_retired_%0d", i), 32'(out_valid8), 32'd0);
    end

    // Random stream with random backpressure and occasional bubbles.
    out_ready = 1'($urandom);
    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      a = ra; b = rb; sub = rs; in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        @(negedge clock);
        acc = in_ready;
        tick();
        out_ready = 1'($urandom);
      end
      chk($sformatf("rand_accept_%0d", n), 32'(acc), 32'd1);
      if (acc) exp_q.push_back(mask(model(ra, rb, rs)));
      in_valid = 1'b0;
      if ($urandom_range(3) == 0) begin
        tick();
        out_ready = 1'($urandom);
      end
    end
    drain("random");

    // Fill the pipe under backpressure, then reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = tbl[i+5].a; b = tbl[i+5].b; sub = tbl[i+5].sub; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", sum, 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    a = tbl[1].a; b = tbl[1].b; sub = tbl[1].sub; in_valid = 1'b1;
    @(negedge clock);
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    e = mask('{tbl[1].sum, tbl[1].cout, tbl[1].ovf, tbl[1].zero});
    exp_q.push_back(e);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("postrst_valid_c%0d", c), 32'(out_valid), 32'(c == 4));
    end
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
